// File: rtl/ptosda_pkg.sv
// Shared definitions for the parallel-to-serial bus driver: state encoding,
// default word width and the frame length used by neighbouring stages.
package ptosda_pkg;

    localparam int DATA_W_DEFAULT = 4;
    localparam int FRAME_CYC      = 6 + 3 * DATA_W_DEFAULT;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        REQ   = 4'd1,
        START = 4'd2,
        SETUP = 4'd3,
        HIGH  = 4'd4,
        LOW   = 4'd5,
        PSTOP = 4'd6,
        SHIGH = 4'd7,
        STOP  = 4'd8
    } state_t;

    // Bit-counter width: enough to index DATA_W bits, never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ptosda.sv
// Requests a parallel word, then drives it MSB-first onto scl/sda framed by a
// start condition (sda falls, scl high) and a stop condition (sda rises, scl high).
module ptosda
    import ptosda_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    output logic              ask_for_data,
    output logic              scl,
    output logic              sda,
    output logic              busy
);

    localparam int CNT_W = cnt_w(DATA_W);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   shift_r;
    logic [CNT_W-1:0]    bitcnt_r;

    // State register
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state sequencing; each bit spends SETUP/HIGH/LOW, so sda only moves while scl is low
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE:    state_nxt_s = REQ;
            REQ:     state_nxt_s = START;
            START:   state_nxt_s = SETUP;
            SETUP:   state_nxt_s = HIGH;
            HIGH:    state_nxt_s = LOW;
            LOW: begin
                if (bitcnt_r == '0) begin
                    state_nxt_s = PSTOP;
                end else begin
                    state_nxt_s = SETUP;
                end
            end
            PSTOP:   state_nxt_s = SHIGH;
            SHIGH:   state_nxt_s = STOP;
            STOP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Registered bus outputs and datapath, updated on the edge that leaves each state
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            ask_for_data <= 1'b0;
            scl          <= 1'b1;
            sda          <= 1'b1;
            busy         <= 1'b0;
            shift_r      <= '0;
            bitcnt_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    ask_for_data <= 1'b1;
                end
                REQ: begin
                    ask_for_data <= 1'b0;
                    shift_r      <= data;
                    sda          <= 1'b0;
                    busy         <= 1'b1;
                end
                START: begin
                    scl      <= 1'b0;
                    bitcnt_r <= CNT_W'(DATA_W - 1);
                end
                SETUP: begin
                    sda <= shift_r[bitcnt_r];
                end
                HIGH: begin
                    scl <= 1'b1;
                end
                LOW: begin
                    scl <= 1'b0;
                    if (bitcnt_r != '0) begin
                        bitcnt_r <= bitcnt_r - CNT_W'(1);
                    end
                end
                PSTOP: begin
                    sda <= 1'b0;
                end
                SHIGH: begin
                    scl <= 1'b1;
                end
                STOP: begin
                    sda  <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    ask_for_data <= 1'b0;
                    scl          <= 1'b1;
                    sda          <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptosda.sv
// Bench for ptosda: a word source feeding a scoreboard queue, and bus monitors
// that decode frames from scl/sda and watch the request handshake.
module tb_ptosda;
    import ptosda_pkg::*;

    localparam int W = DATA_W_DEFAULT;

    logic         sclk = 1'b0;
    logic         rst  = 1'b0;
    logic [W-1:0] data = '0;
    logic         ask_for_data;
    logic         scl;
    logic         sda;
    logic         busy;

    ptosda #(.DATA_W(W)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .data         (data),
        .ask_for_data (ask_for_data),
        .scl          (scl),
        .sda          (sda),
        .busy         (busy)
    );

    always #50 sclk = ~sclk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           ecnt     = 0;
    int           frames_seen = 0;
    int           violations  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] stim_q[$];
    logic [W-1:0] src_word;

    logic         prev_scl = 1'b1;
    logic         prev_sda = 1'b1;
    logic         in_frame = 1'b0;
    int           nbits = 0;
    int           extra = 0;
    logic [W-1:0] word = '0;
    logic         prev_ask = 1'b0;
    int           last_ask = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic wait_edge(input int n);
        while (ecnt < n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    // Edge index since reset release: E1 is the first posedge after release
    always @(posedge sclk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    // Word source: answers each request 28 ns later and records the expected frame
    always @(posedge ask_for_data) begin
        #28;
        if (stim_q.size() > 0) src_word = stim_q.pop_front();
        else                   src_word = W'($urandom_range(0, (1 << W) - 1));
        data = src_word;
        exp_q.push_back(src_word);
    end

    // Bus decoder: start/stop detection, bit capture on scl rise, scoreboard compare
    initial forever begin
        @(negedge sclk);
        if (!rst) begin
            in_frame = 1'b0;
            prev_scl = 1'b1;
            prev_sda = 1'b1;
        end else begin
            if (scl && prev_scl && (sda != prev_sda)) begin
                if (!sda && !in_frame) begin
                    in_frame = 1'b1;
                    nbits = 0;
                    extra = 0;
                    word  = '0;
                end else if (sda && in_frame && nbits == W && extra == 1) begin
                    in_frame = 1'b0;
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got %0d, required no frame", word);
                    end else begin
                        check("frame_word", int'(word), int'(exp_q.pop_front()));
                    end
                end else begin
                    violations++;
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_protocol: sda went to %0b while scl=1 at edge %0d, required stable",
                             sda, ecnt);
                end
            end else if (scl && !prev_scl && in_frame) begin
                if (nbits < W) begin
                    word = {word[W-2:0], sda};
                    nbits++;
                end else begin
                    extra++;
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    // Request monitor: single-cycle pulse, never while busy, fixed frame period
    initial forever begin
        @(negedge sclk);
        if (!rst) begin
            prev_ask = 1'b0;
            last_ask = -1;
        end else begin
            if (ask_for_data) begin
                check("ask_while_busy", int'(busy), 0);
                check("ask_width", int'(prev_ask), 0);
                if (last_ask >= 0) check("ask_period", ecnt - last_ask, FRAME_CYC);
                last_ask = ecnt;
            end
            prev_ask = ask_for_data;
        end
    end

    logic [W-1:0] pat;

    initial begin
        // Frame 0: 1010, frames 1..16: 0..15, 17: 5 (changed mid-frame), 18: A, 19: F, 20: 0
        stim_q.push_back(4'hA);
        for (int i = 0; i < 16; i++) stim_q.push_back(W'(i));
        stim_q.push_back(4'h5);
        stim_q.push_back(4'hA);
        stim_q.push_back(4'hF);
        stim_q.push_back(4'h0);

        #110;
        check("rst_scl", int'(scl), 1);
        check("rst_sda", int'(sda), 1);
        check("rst_ask", int'(ask_for_data), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;

        wait_edge(1);
        check("e1_ask", int'(ask_for_data), 1);
        check("e1_busy", int'(busy), 0);
        wait_edge(2);
        check("e2_ask", int'(ask_for_data), 0);
        check("e2_busy", int'(busy), 1);
        check("e2_start_sda", int'(sda), 0);
        check("e2_start_scl", int'(scl), 1);
        wait_edge(3);
        check("e3_scl", int'(scl), 0);
        pat = 4'b1010;
        for (int i = 0; i < W; i++) begin
            wait_edge(5 + 3 * i);
            check("bit_scl_high", int'(scl), 1);
            check("bit_sda", int'(sda), int'(pat[W-1-i]));
        end
        wait_edge(18);
        check("e18_stop_sda", int'(sda), 1);
        check("e18_stop_scl", int'(scl), 1);
        check("e18_busy", int'(busy), 0);
        wait_edge(19);
        check("e19_ask", int'(ask_for_data), 1);

        // Change the source word during bit 2 of the frame carrying 5
        wait_edge(1 + FRAME_CYC * 17 + 7);
        data = 4'hA;

        // Reset while scl is high for bit 2 of frame 21
        wait_edge(1 + FRAME_CYC * 21 + 7);
        check("pre_reset_scl", int'(scl), 1);
        #19;
        rst = 1'b0;
        #1;
        check("async_rst_scl", int'(scl), 1);
        check("async_rst_sda", int'(sda), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ask", int'(ask_for_data), 0);
        check("frames_before_reset", frames_seen, 21);
        exp_q.delete();
        #60;
        rst = 1'b1;

        wait_edge(1);
        check("rel_e1_ask", int'(ask_for_data), 1);
        check("rel_e1_sda", int'(sda), 1);
        check("rel_e1_scl", int'(scl), 1);
        wait_edge(2);
        check("rel_e2_busy", int'(busy), 1);
        check("rel_e2_sda", int'(sda), 0);

        wait_edge(3 * FRAME_CYC);
        @(negedge sclk);
        #1;
        check("frames_total", frames_seen, 24);
        check("scoreboard_empty", exp_q.size(), 0);
        check("protocol_violations", violations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
